// File: rtl/he_mem_port_arbiter.sv
// Merges a split read/write upstream channel onto one single-port memory bus.
// Writes are posted into a small FIFO that read hits forward from.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

module he_mem_port_arbiter #(
    parameter int BIT_WIDTH  = `BIT_WIDTH,
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_read_i,
    input  logic [ADDR_W-1:0]    up_addr_read_i,
    output logic [BIT_WIDTH-1:0] up_rdata_o,
    output logic                 up_resp_read_o,
    input  logic                 up_write_i,
    input  logic [ADDR_W-1:0]    up_addr_write_i,
    input  logic [BIT_WIDTH-1:0] up_wdata_i,
    output logic                 up_resp_write_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [BIT_WIDTH-1:0] mem_wdata_o,
    input  logic [BIT_WIDTH-1:0] mem_rdata_i,
    input  logic                 mem_resp_i,
    output logic                 wb_empty_o
);
    localparam int IDX_W = $clog2(WBUF_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD    = 2'd1;
    localparam logic [1:0] S_WR    = 2'd2;
    localparam logic [1:0] S_RRESP = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W-1:0]     w_head_next;
    logic [PTR_W-1:0]     w_tail_next;
    logic [PTR_W-1:0]     w_count;
    logic [ADDR_W-1:0]    r_wb_addr [WBUF_DEPTH];
    logic [BIT_WIDTH-1:0] r_wb_data [WBUF_DEPTH];
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [BIT_WIDTH-1:0] r_rdata;
    logic                 r_resp_read;
    logic                 r_resp_write;
    logic                 r_wb_empty;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_enq;
    logic                 w_pop;
    logic                 w_rd_req;
    logic                 w_hit;
    logic                 w_hit_resp;
    logic [BIT_WIDTH-1:0] w_hit_data;
    logic [IDX_W-1:0]     w_scan_idx;
    logic [IDX_W-1:0]     w_head_idx;
    logic [IDX_W-1:0]     w_tail_idx;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_count    = r_tail - r_head;
    assign w_empty    = (r_tail == r_head);
    assign w_full     = (r_tail == {~r_head[PTR_W-1], w_head_idx});
    // The ack-pending guard keeps a still-held request from being queued twice.
    assign w_enq      = up_write_i && !w_full && !r_resp_write;
    assign w_pop      = (r_state == S_WR) && mem_resp_i;
    assign w_rd_req   = up_read_i && !r_resp_read && (r_state == S_IDLE);

    assign w_head_next = r_head + PTR_W'(w_pop);
    assign w_tail_next = r_tail + PTR_W'(w_enq);

    // Scan oldest to youngest so the last match wins; a same-cycle write is youngest of all.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_scan_idx = w_head_idx;
        for (int a = 0; a < WBUF_DEPTH; a++) begin
            w_scan_idx = w_head_idx + IDX_W'(a);
            if ((PTR_W'(a) < w_count) && (r_wb_addr[w_scan_idx] == up_addr_read_i)) begin
                w_hit      = 1'b1;
                w_hit_data = r_wb_data[w_scan_idx];
            end
        end
        if (w_enq && (up_addr_write_i == up_addr_read_i)) begin
            w_hit      = 1'b1;
            w_hit_data = up_wdata_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hit_resp   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_full) begin
                    w_state_next = S_WR;
                end else if (w_rd_req) begin
                    if (w_hit) begin
                        w_hit_resp = 1'b1;
                    end else begin
                        w_state_next = S_RD;
                    end
                end else if (!w_empty) begin
                    w_state_next = S_WR;
                end
            end
            S_RD:    if (mem_resp_i) w_state_next = S_RRESP;
            S_WR:    if (mem_resp_i) w_state_next = S_IDLE;
            S_RRESP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_rd_addr    <= '0;
            r_rdata      <= '0;
            r_resp_read  <= 1'b0;
            r_resp_write <= 1'b0;
            r_wb_empty   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_head       <= w_head_next;
            r_tail       <= w_tail_next;
            r_resp_write <= w_enq;
            r_resp_read  <= w_hit_resp || ((r_state == S_RD) && mem_resp_i);
            if (w_hit_resp) begin
                r_rdata <= w_hit_data;
            end else if ((r_state == S_RD) && mem_resp_i) begin
                r_rdata <= mem_rdata_i;
            end
            if ((r_state == S_IDLE) && (w_state_next == S_RD)) begin
                r_rd_addr <= up_addr_read_i;
            end
            r_wb_empty <= (w_head_next == w_tail_next) && (w_state_next == S_IDLE);
        end
    end

    // Entry storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wb_addr[w_tail_idx] <= up_addr_write_i;
            r_wb_data[w_tail_idx] <= up_wdata_i;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (r_state == S_RD) begin
            mem_addr_o = r_rd_addr;
        end else if (r_state == S_WR) begin
            mem_addr_o  = r_wb_addr[w_head_idx];
            mem_wdata_o = r_wb_data[w_head_idx];
        end
    end

    assign mem_read_o      = (r_state == S_RD);
    assign mem_write_o     = (r_state == S_WR);
    assign up_rdata_o      = r_rdata;
    assign up_resp_read_o  = r_resp_read;
    assign up_resp_write_o = r_resp_write;
    assign wb_empty_o      = r_wb_empty;

endmodule

// File: doc/he_mem_port_arbiter.md
# he_mem_port_arbiter

Memory-side stage directly downstream of `wrapper_top`. It merges the wrapper's separate read channel (`mem_read_o`/`addr_read_o`/`data_i`/`mem_resp_read_i`) and write channel (`mem_write_o`/`addr_write_o`/`data_o`/`mem_resp_write_i`) onto one shared single-port memory bus. A posted write buffer acknowledges writes in one cycle. Reads forward from the buffer on an address hit and otherwise go to memory. `wb_empty_o` tells the top level that every write has been committed.

## Interface
- `BIT_WIDTH`, default `` `BIT_WIDTH ``: data word width.
- `ADDR_W`, default 32: address width.
- `WBUF_DEPTH`, default 4: write buffer entries; must be a power of 2 and ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `up_read_i` in 1: read request from the wrapper; held until its response.
- `up_addr_read_i` in ADDR_W: read address.
- `up_rdata_o` out BIT_WIDTH: read data; valid while `up_resp_read_o`=1.
- `up_resp_read_o` out 1: one-cycle read response pulse.
- `up_write_i` in 1: write request; held until its response.
- `up_addr_write_i` in ADDR_W: write address.
- `up_wdata_i` in BIT_WIDTH: write data.
- `up_resp_write_o` out 1: one-cycle write acknowledge.
- `mem_read_o` out 1: memory read strobe; held until `mem_resp_i`.
- `mem_write_o` out 1: memory write strobe; held until `mem_resp_i`.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_wdata_o` out BIT_WIDTH: memory write data.
- `mem_rdata_i` in BIT_WIDTH: memory read data; sampled when `mem_resp_i`=1.
- `mem_resp_i` in 1: memory completion for the current access.
- `wb_empty_o` out 1: buffer empty and FSM in IDLE.

## Operation
**Write buffer**
- Circular FIFO with head/tail pointers of width log2(WBUF_DEPTH)+1; full/empty come from the MSB compare.
- Enqueue when `up_write_i`=1, count<WBUF_DEPTH (sampled at cycle start) and `up_resp_write_o`=0. The last condition stops a held request from being accepted twice.
- When full, the write request stalls until a drain completes. Enqueue and drain may happen in the same cycle.

**Read path**
- A read is considered when `up_read_i`=1, `up_resp_read_o`=0 and the FSM is in IDLE.
- Hit check: compare `up_addr_read_i` against all valid entries, plus a write being enqueued in the same cycle, which counts as older than the read.
- On a hit, forward the youngest matching data, with no memory access.

**FSM states and transitions**
- States: IDLE, RD, WR, RRESP.
- IDLE → WR if the buffer is full.
- Otherwise IDLE → RD on a read miss; a read hit responds directly.
- Otherwise IDLE → WR if the buffer is non-empty.
- RD drives `mem_read_o`=1 and `mem_addr_o`=read address. On `mem_resp_i` it latches `mem_rdata_i` and goes to RRESP.
- RRESP pulses `up_resp_read_o` and returns to IDLE.
- WR drives `mem_write_o`=1 with the head entry's address and data. On `mem_resp_i` it pops the head and returns to IDLE.
- Reads have priority over drain unless the buffer is full.

**General rules**
- `mem_read_o` and `mem_write_o` are never both 1.
- `mem_resp_i` outside RD/WR is ignored.
- `up_rdata_o` holds its last value between responses.

**Reset**
- All outputs go to 0 immediately, including in the middle of a transaction, and the buffer is discarded.
- The FSM returns to IDLE.
- `wb_empty_o` reads 1 from the first clock edge after `rst` deasserts.

## Timing
- Write ack: request sampled in cycle N → `up_resp_write_o`=1 in N+1. The entry is visible to forwarding from N+1.
- Read hit: sampled in N → `up_resp_read_o`=1 with data in N+1.
- Read miss: sampled in N → `mem_read_o`=1 from N+1. If `mem_resp_i` is high in cycle M, the read response is in M+1 and the FSM is in IDLE at M+2.
- Drain: `mem_write_o`=1 from the cycle after the IDLE decision until the `mem_resp_i` cycle. The pop is visible the next cycle.
- Minimum drain throughput is one entry per 2 cycles plus memory latency.
- `wb_empty_o` is registered. It rises the cycle after the final pop when no read is in flight.

## Test plan
- Reset mid-drain: assert `rst`=0 while `mem_write_o`=1 → all outputs 0 immediately; `wb_empty_o`=1 after release; no stale `up_resp_*` pulse.
- Four back-to-back writes, addresses 0x10–0x13, data 0xcafebabe, memory responds after 3 cycles → four acks on consecutive request cycles. The fifth write stalls until the first pop. Memory sees the writes in order 0x10..0x13.
- Write 0x20=0xdeadbeef, then read 0x20 before drain → response 1 cycle later with 0xdeadbeef and no `mem_read_o`. Repeat with a same-cycle write and read to 0x20 → same result.
- Read 0x40 (miss) with the buffer holding 2 entries, memory returns 0x12345678 → `mem_read_o` precedes any `mem_write_o`; `up_rdata_o`=0x12345678 at M+1.
- Buffer full plus a pending read miss → a drain is issued first, then the read; `mem_read_o` and `mem_write_o` never overlap.
- Two writes to 0x30 (0x1, then 0x2), then read 0x30 → returns 0x2. After drain `wb_empty_o`=1 and memory[0x30]=0x2.
